// File: rtl/and_gate_checker_pkg.sv
// -----------------------------------------------------------------------------
// and_gate_checker_pkg
// Shared definitions for the AND-gate checker: FSM state encoding, the
// stimulus vector table, vector count and mismatch-counter width.
// No ports (package). Imported by and_gate_checker and its sub-module.
// -----------------------------------------------------------------------------
package and_gate_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int IDX_W       = 2;
  localparam int ERR_COUNT_W = 3;

  // Entry n is {stim_1, stim_2} for vector n. Gray order so that only one
  // gate input toggles between consecutive vectors.
  localparam logic [NUM_VECTORS-1:0][1:0] VECTOR_TABLE = {2'b01, 2'b11, 2'b10, 2'b00};

  // Golden AND response for a {stim_1, stim_2} pair.
  function automatic logic expected_result(input logic [1:0] stim);
    return stim[1] & stim[0];
  endfunction

endpackage

// File: rtl/and_gate_checker_dwell_timer.sv
// -----------------------------------------------------------------------------
// and_gate_checker_dwell_timer
// Down-counter that measures how long a vector is held on the gate inputs.
// load reloads DWELL_CYCLES-1, dec counts down by one, zero flags count==0.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset (count cleared to 0)
//   load   in   reload with DWELL_CYCLES-1
//   dec    in   decrement by one (ignored when load is high)
//   zero   out  count is zero
// -----------------------------------------------------------------------------
module and_gate_checker_dwell_timer
  import and_gate_checker_pkg::*;
#(
  parameter int DWELL_CYCLES = 10,
  parameter int WIDTH        = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [WIDTH-1:0] count_q;

  // Load has priority so a new vector always gets its full dwell time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= WIDTH'(DWELL_CYCLES - 1);
    end else if (dec) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/and_gate_checker.sv
// -----------------------------------------------------------------------------
// and_gate_checker
// Walks a 2-input AND gate through its four input combinations (Gray order),
// holds each for DWELL_CYCLES cycles, samples the gate result for one cycle
// and reports the per-pass mismatch count and bitmap.
// Build option: define AND_GATE_CHECKER_LOOP_EN to make DONE a one-cycle
// state that restarts automatically while start is held (otherwise DONE is
// held until start).
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   start       in   begin a pass (sampled in IDLE / DONE)
//   stim_1      out  AND gate input_1
//   stim_2      out  AND gate input_2
//   dut_result  in   AND gate output
//   busy        out  in DRIVE or SAMPLE
//   done        out  in DONE
//   pass        out  last completed pass had no mismatches
//   err_count   out  mismatch count of last completed pass
//   err_vec     out  per-vector mismatch bitmap of last completed pass
// -----------------------------------------------------------------------------
module and_gate_checker
  import and_gate_checker_pkg::*;
#(
  parameter int DWELL_CYCLES = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   stim_1,
  output logic                   stim_2,
  input  logic                   dut_result,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_COUNT_W-1:0] err_count,
  output logic [NUM_VECTORS-1:0] err_vec
);

  localparam int TIMER_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [ERR_COUNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_VECTORS-1:0]   bits_q, bits_d;
  logic [1:0]               stim_d;
  logic                     busy_d, done_d, pass_d;
  logic [ERR_COUNT_W-1:0]   err_count_d;
  logic [NUM_VECTORS-1:0]   err_vec_d;
  logic                     timer_load, timer_dec, timer_zero;
  logic                     mismatch;

  and_gate_checker_dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .WIDTH        (TIMER_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .dec   (timer_dec),
    .zero  (timer_zero)
  );

  assign mismatch = (dut_result != expected_result(VECTOR_TABLE[idx_q]));

  // Next-state and next-output logic. Outputs are computed from the next
  // state so they can be registered and still line up with the state.
  // The final SAMPLE folds its own mismatch into the published results so
  // the last vector is included on DONE entry.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    bits_d      = bits_q;
    pass_d      = pass;
    err_count_d = err_count;
    err_vec_d   = err_vec;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_DRIVE;
          idx_d      = '0;
          cnt_d      = '0;
          bits_d     = '0;
          timer_load = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (timer_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          cnt_d         = cnt_q + ERR_COUNT_W'(1);
          bits_d[idx_q] = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d     = ST_DONE;
          pass_d      = (cnt_d == '0);
          err_count_d = cnt_d;
          err_vec_d   = bits_d;
        end else begin
          state_d    = ST_DRIVE;
          idx_d      = idx_q + IDX_W'(1);
          timer_load = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d    = ST_DRIVE;
          idx_d      = '0;
          cnt_d      = '0;
          bits_d     = '0;
          timer_load = 1'b1;
        end else begin
`ifdef AND_GATE_CHECKER_LOOP_EN
          state_d = ST_IDLE;
`else
          state_d = ST_DONE;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
    stim_d = busy_d ? VECTOR_TABLE[idx_d] : 2'b00;
  end

  // State and registered outputs; reset discards any partial pass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      bits_q    <= '0;
      stim_1    <= 1'b0;
      stim_2    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      err_vec   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      stim_1    <= stim_d[1];
      stim_2    <= stim_d[0];
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_count <= err_count_d;
      err_vec   <= err_vec_d;
    end
  end

endmodule

// File: tb/tb_and_gate_checker.sv
// -----------------------------------------------------------------------------
// tb_and_gate_checker
// Self-checking bench for and_gate_checker (DWELL_CYCLES = 10). The gate under
// test is modelled by a 4-entry truth table indexed by {stim_1, stim_2}, which
// lets the bench emulate a correct gate, stuck-at faults or random faults.
// Honours AND_GATE_CHECKER_LOOP_EN for the DONE-handling checks.
// -----------------------------------------------------------------------------
module tb_and_gate_checker;

  localparam int DWELL       = 10;
  localparam int VEC_CYCLES  = DWELL + 1;
  localparam int PASS_CYCLES = 4 * VEC_CYCLES;

  typedef struct {
    string      name;
    logic [3:0] tt;
    int         glitch_k;
    logic       exp_pass;
    logic [2:0] exp_cnt;
    logic [3:0] exp_vec;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stim_1, stim_2;
  logic       dut_result;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] err_vec;
  logic [3:0] gate_tt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Gate under test: truth table lookup keyed by {input_1, input_2}.
  assign dut_result = gate_tt[{stim_1, stim_2}];

  and_gate_checker #(.DWELL_CYCLES(DWELL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stim_1     (stim_1),
    .stim_2     (stim_2),
    .dut_result (dut_result),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .err_vec    (err_vec)
  );

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the Gray sequence, compare the faulty gate against a
  // perfect AND and tally the disagreements.
  task automatic model_pass(input logic [3:0] tt, output logic exp_pass,
                            output logic [2:0] exp_cnt, output logic [3:0] exp_vec);
    int   g;
    logic s1, s2;
    exp_vec = '0;
    exp_cnt = '0;
    for (int n = 0; n < 4; n++) begin
      g  = n ^ (n >> 1);
      s1 = g[0];
      s2 = g[1];
      if (tt[{s1, s2}] != (s1 & s2)) begin
        exp_vec[n] = 1'b1;
        exp_cnt++;
      end
    end
    exp_pass = (exp_cnt == 0);
  endtask

  // Expected {stim_1, stim_2} k cycles after the first DRIVE cycle.
  function automatic logic [1:0] expected_stim(input int k);
    int idx, g;
    idx = k / VEC_CYCLES;
    g   = idx ^ (idx >> 1);
    return {g[0], g[1]};
  endfunction

  // One full pass from IDLE/DONE; glitch_k >= 0 pulses start at that cycle.
  task automatic apply_stimulus(input string name, input logic [3:0] tt, input int glitch_k,
                                input logic exp_pass, input logic [2:0] exp_cnt,
                                input logic [3:0] exp_vec);
    gate_tt = tt;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < PASS_CYCLES; k++) begin
      check_output($sformatf("%s busy/done/stim k=%0d", name, k),
                   16'({busy, done, stim_1, stim_2}), 16'({2'b10, expected_stim(k)}));
      if (k == glitch_k) start = 1'b1;
      step();
      start = 1'b0;
    end
    check_output({name, " done state"}, 16'({busy, done, stim_1, stim_2}), 16'b0100);
    check_output({name, " pass"}, 16'(pass), 16'(exp_pass));
    check_output({name, " err_count"}, 16'(err_count), 16'(exp_cnt));
    check_output({name, " err_vec"}, 16'(err_vec), 16'(exp_vec));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t       vectors[4];
    logic [3:0] tt;
    logic       e_pass;
    logic [2:0] e_cnt;
    logic [3:0] e_vec;
    int         cyc;

    vectors[0] = '{"good_gate",  4'b1000, -1, 1'b1, 3'd0, 4'b0000};
    vectors[1] = '{"stuck_at_0", 4'b0000, -1, 1'b0, 3'd1, 4'b0100};
    vectors[2] = '{"stuck_at_1", 4'b1111, -1, 1'b0, 3'd3, 4'b1011};
    vectors[3] = '{"start_glitch", 4'b1000, 15, 1'b1, 3'd0, 4'b0000};

    rst_n   = 1'b0;
    start   = 1'b0;
    gate_tt = 4'b1000;
    repeat (3) step();
    check_output("reset outputs", 16'({stim_1, stim_2, busy, done, pass, err_count, err_vec}), 16'd0);
    rst_n = 1'b1;
    repeat (3) step();
    check_output("idle without start", 16'({stim_1, stim_2, busy, done}), 16'd0);

    for (int i = 0; i < 4; i++) begin
      apply_stimulus(vectors[i].name, vectors[i].tt, vectors[i].glitch_k,
                     vectors[i].exp_pass, vectors[i].exp_cnt, vectors[i].exp_vec);
    end

`ifdef AND_GATE_CHECKER_LOOP_EN
    step();
    check_output("loop done one cycle", 16'({busy, done}), 16'b00);
    start = 1'b1;
    cyc = 0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    check_output("loop first done", 16'(done), 16'd1);
    for (int r = 0; r < 2; r++) begin
      step();
      cyc = 1;
      check_output("loop done width", 16'(done), 16'd0);
      while (!done && cyc < 100) begin
        step();
        cyc++;
      end
      check_output("loop period", 16'(cyc), 16'd45);
    end
    repeat (10) step();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    check_output("loop final done", 16'(done), 16'd1);
    step();
    check_output("loop back to idle", 16'({busy, done, stim_1, stim_2}), 16'd0);
    repeat (3) step();
    check_output("loop stays idle", 16'({busy, done}), 16'd0);
`else
    repeat (5) step();
    check_output("done held", 16'({busy, done, stim_1, stim_2}), 16'b0100);
    check_output("results held", 16'({pass, err_count, err_vec}), 16'({1'b1, 3'd0, 4'b0000}));
`endif

    for (int r = 0; r < 6; r++) begin
      tt = 4'($urandom);
      model_pass(tt, e_pass, e_cnt, e_vec);
      apply_stimulus($sformatf("random_%0d", r), tt, -1, e_pass, e_cnt, e_vec);
    end

    apply_stimulus("pre_reset", 4'b0000, -1, 1'b0, 3'd1, 4'b0100);
    gate_tt = 4'b1111;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (25) step();
    check_output("mid vector 2 busy", 16'({busy, stim_1, stim_2}), 16'b111);
    rst_n = 1'b0;
    start = 1'b1;
    step();
    check_output("reset mid pass", 16'({stim_1, stim_2, busy, done, pass, err_count, err_vec}), 16'd0);
    step();
    check_output("reset beats start", 16'({busy, done}), 16'd0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (50) step();
    check_output("no done after reset", 16'({stim_1, stim_2, busy, done, pass, err_count, err_vec}), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/and_gate_checker.md
AND_GATE_CHECKER -- requirements
Module: and_gate_checker

Interface
REQ-001 Parameter: DWELL_CYCLES, default 10, cycles each stimulus vector is held before sampling (legal range 1..255).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  level; sampled in IDLE/DONE to begin a check pass.
REQ-005 stim_1  output  1  drives AND gate input_1.
REQ-006 stim_2  output  1  drives AND gate input_2.
REQ-007 dut_result  input  1  AND gate and_result, combinational from stim_1/stim_2.
REQ-008 busy  output  1  high in DRIVE or SAMPLE.
REQ-009 done  output  1  high while in DONE.
REQ-010 pass  output  1  last completed pass had zero mismatches.
REQ-011 err_count  output  3  mismatches in last completed pass (0..4).
REQ-012 err_vec  output  4  per-vector mismatch bitmap of last completed pass; bit n = vector n.

Function
REQ-013 Vector table, index 0..3: {stim_1,stim_2} = 00, 10, 11, 01 (Gray order; one input toggles per step); expected = stim_1 & stim_2.
REQ-014 States: IDLE, DRIVE, SAMPLE, DONE; all outputs registered.
REQ-015 IDLE: stim=00, busy=0; start=1 -> DRIVE with idx=0, internal mismatch counter and bitmap cleared.
REQ-016 DRIVE: stim=vector[idx] for exactly DWELL_CYCLES cycles (down-counter loaded with DWELL_CYCLES-1 on entry; exit at 0), then SAMPLE.
REQ-017 SAMPLE: one cycle, stim held; dut_result != expected -> internal counter +1 and bitmap[idx] set; idx<3 -> idx+1, DRIVE; idx=3 -> DONE.
REQ-018 Each vector occupies DWELL_CYCLES+1 cycles; done rises 4*(DWELL_CYCLES+1) cycles after the first DRIVE cycle.
REQ-019 On DONE entry: pass, err_count, err_vec loaded from internal state; they hold until next DONE entry or reset.
REQ-020 DONE: stim=00, done=1.
REQ-021 start while busy is ignored; no restart, no state change.
REQ-022 Internal counter saturation unnecessary: max 4 fits 3 bits; no wrap permitted.

Reset
REQ-023 rst_n=0 at a rising edge -> IDLE; stim_1, stim_2, busy, done, pass, err_count, err_vec all 0, idx=0, timer=0.
REQ-024 Reset mid-pass (any state) discards partial results; no DONE update occurs.
REQ-025 rst_n has priority over start on the same edge.

Configuration
REQ-026 Macro AND_GATE_CHECKER_LOOP_EN.
REQ-027 Undefined: DONE held until start=1, then DRIVE idx 0 (one-shot).
REQ-028 Defined: DONE lasts exactly one cycle; then DRIVE idx 0 if start=1, else IDLE; pass/err_count/err_vec still update only on DONE entry.

Structure
REQ-029 Package and_gate_checker_pkg holds state enum, vector table constant, NUM_VECTORS=4, and err_count width constant.
REQ-030 Sub-module and_gate_checker_dwell_timer: load/count-down/zero flag, width from DWELL_CYCLES.

Verification (DWELL_CYCLES=10, correct AND gate unless stated)
REQ-031 Reset, start pulse 1 cycle -> stim sequence 00,10,11,01 each 11 cycles; done at cycle 44 after first DRIVE; pass=1, err_count=0, err_vec=0000.
REQ-032 dut_result stuck-at-0 -> pass=0, err_count=1, err_vec=0100.
REQ-033 dut_result stuck-at-1 -> pass=0, err_count=3, err_vec=1011.
REQ-034 rst_n low during DRIVE of vector 2 -> next edge all outputs 0, state IDLE; prior pass results cleared.
REQ-035 start pulsed during DRIVE vector 1 -> ignored; sequence and done timing unchanged from REQ-031.
REQ-036 LOOP_EN defined, start held high -> done pulses 1 cycle every 45 cycles; start dropped -> IDLE after current DONE.
